crypto_reg_arbiter: RTL
=======================

Name: crypto_reg_arbiter

Overview:
- Sequences and shares a bank of NUM_REGS 16-bit crypto data registers between two requesters: the system bus (B) and the crypto core datapath (C).
- Each register has two ports. Bus-side: save_info_bus/send_info_bus. Core-side: save_info_reg/send_info_reg.
- Converts req/ack transactions into one-cycle save/send strobes, captures read data, and serialises all accesses.
- Sits between the bus interface, the crypto FSM and the register bank.

Parameters:
- NUM_REGS, 8, number of data registers in the bank.
- DATA_W, 16, register width.
- ADDR_W, 3, register index width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- b_req  input  1  bus request; held with b_we/b_addr/b_wdata stable until b_ack.
- b_we  input  1  1 = write (save), 0 = read (send).
- b_addr  input  ADDR_W  bus register index.
- b_wdata  input  DATA_W  bus write data.
- b_ack  output  1  one-cycle completion pulse.
- b_err  output  1  valid with b_ack; 1 = rejected access.
- b_rdata  output  DATA_W  read data; valid with b_ack on reads.
- c_req, c_we, c_addr, c_wdata, c_ack, c_err, c_rdata: core-side equivalents, same widths and rules.
- save_info_bus  output  NUM_REGS  one-hot bus-side save strobe.
- send_info_bus  output  NUM_REGS  one-hot bus-side send strobe.
- save_info_reg  output  NUM_REGS  one-hot core-side save strobe.
- send_info_reg  output  NUM_REGS  one-hot core-side send strobe.
- save_data_bus  output  DATA_W  write data to the bank's bus-side input.
- save_data_reg  output  DATA_W  write data to the bank's core-side input.
- send_data_bus_all  input  NUM_REGS*DATA_W  concatenated bus-side outputs; reg i at [i*DATA_W +: DATA_W].
- send_data_reg_all  input  NUM_REGS*DATA_W  concatenated core-side outputs.

Behaviour:
- Reset: all strobes 0, save_data_* 0, *_ack 0, *_err 0, *_rdata 0, FSM IDLE, last_grant = C (bus wins first tie).
- Reset mid-transaction: the transaction is dropped, no ack is issued, and the requester must re-request.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
- IDLE, arbitration:
  - Only one requester active: grant it.
  - Both active: round-robin, grant the one not equal to last_grant.
  - On grant, latch we/addr/wdata/owner, update last_grant, go to ISSUE.
- ISSUE, single cycle:
  - Exactly one strobe bit is asserted, on the owner's port type: B uses the *_bus strobes, C uses the *_reg strobes.
  - Write: assert save_info_x[addr] with save_data_x = wdata. Go to RESP.
  - Read: assert send_info_x[addr]. Go to RD_WAIT.
- RD_WAIT: the register output updated at the ISSUE edge. Capture the addressed slice of send_data_x_all into owner rdata. Go to RESP.
- RESP: pulse owner ack for 1 cycle, err = 0. Go to IDLE.
  - A requester may drop req in the cycle after ack.
  - A req still high in IDLE is a new transaction.
- Latency from IDLE grant to ack:
  - Write: ack in cycle 3, i.e. IDLE→ISSUE→RESP, 2 cycles after grant.
  - Read: ack in cycle 4, i.e. IDLE→ISSUE→RD_WAIT→RESP.
- Out-of-range address (addr >= NUM_REGS): no strobe in ISSUE; go to RESP with err = 1; rdata unchanged.
- Simultaneous events:
  - At most one strobe bit across all four vectors in any cycle.
  - Bus-side and core-side saves to the same register are never simultaneous.
- Non-owner outputs: ack/err stay 0 and rdata holds its last value.
- Strobes are 0 in every state except ISSUE.
- Fairness: under continuous requests from both sides, grants alternate B, C, B, C...

Optional Feature:
- Macro: CRYPTO_REG_LOCK_EN.
- When defined, the block adds:
  - Input lock_set  NUM_REGS.
  - Input lock_clr_all  1.
  - An internal lock_mask[NUM_REGS], reset 0.
- lock_mask update each cycle:
  - lock_clr_all = 1: lock_mask <= 0 (clear has priority).
  - Otherwise: lock_mask <= lock_mask | lock_set.
- Any bus access (read or write) to a locked register issues no strobe and gets RESP with b_err = 1. This protects key material.
- Core accesses ignore lock_mask.
- When undefined: no lock ports, no mask, and bus accesses are never rejected for lock.

Test Plan:
- Bus write b_addr=2, b_wdata=16'hA5A5 → save_info_bus=8'b0000_0100 for 1 cycle with save_data_bus=A5A5; b_ack 2 cycles after grant; b_err=0.
- After that write, core read c_addr=2 → send_info_reg=8'b0000_0100; c_ack 3 cycles after grant with c_rdata=16'hA5A5.
- b_req and c_req both asserted in the same cycle after reset → B granted first, then C; the strobes never overlap.
- Core read c_addr=7 with NUM_REGS=6 → no strobe; c_ack with c_err=1.
- Assert rst during RD_WAIT → next cycle IDLE, all outputs 0, no ack issued.
- With CRYPTO_REG_LOCK_EN: lock_set=8'h01, then bus write addr 0 → no strobe, b_err=1. Core write addr 0 of 16'h1234 succeeds. After lock_clr_all, bus write addr 0 succeeds.

Source files
------------

// File: rtl/crypto_reg_arbiter.sv
// Arbitrates bus (B) and core (C) accesses to a crypto register bank, turning req/ack into one-cycle strobes.
// Optional register locking against bus access is enabled by defining CRYPTO_REG_LOCK_EN.
module crypto_reg_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       b_req,
  input  logic                       b_we,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_wdata,
  output logic                       b_ack,
  output logic                       b_err,
  output logic [DATA_W-1:0]          b_rdata,
  input  logic                       c_req,
  input  logic                       c_we,
  input  logic [ADDR_W-1:0]          c_addr,
  input  logic [DATA_W-1:0]          c_wdata,
  output logic                       c_ack,
  output logic                       c_err,
  output logic [DATA_W-1:0]          c_rdata,
`ifdef CRYPTO_REG_LOCK_EN
  input  logic [NUM_REGS-1:0]        lock_set,
  input  logic                       lock_clr_all,
`endif
  output logic [NUM_REGS-1:0]        save_info_bus,
  output logic [NUM_REGS-1:0]        send_info_bus,
  output logic [NUM_REGS-1:0]        save_info_reg,
  output logic [NUM_REGS-1:0]        send_info_reg,
  output logic [DATA_W-1:0]          save_data_bus,
  output logic [DATA_W-1:0]          save_data_reg,
  input  logic [NUM_REGS*DATA_W-1:0] send_data_bus_all,
  input  logic [NUM_REGS*DATA_W-1:0] send_data_reg_all
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                own_c_q, own_c_d;   // 1: core owns the current transaction
  logic                last_c_q, last_c_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;

  logic                grant_c;
  logic                in_range, locked, reject;
  logic [NUM_REGS-1:0] sel_onehot;
  logic [NUM_REGS*DATA_W-1:0] rd_src, rd_shift;
  logic [DATA_W-1:0]   rd_slice;

  // Shifting past the vector width yields zero, so out-of-range indices select nothing.
  assign sel_onehot = NUM_REGS'(1) << addr_q;
  assign in_range   = (int'(addr_q) < NUM_REGS);
  assign rd_src     = own_c_q ? send_data_reg_all : send_data_bus_all;
  assign rd_shift   = rd_src >> (int'(addr_q) * DATA_W);
  assign rd_slice   = rd_shift[DATA_W-1:0];

`ifdef CRYPTO_REG_LOCK_EN
  logic [NUM_REGS-1:0] lock_mask_q, lock_mask_d;

  always_comb begin
    lock_mask_d = lock_clr_all ? '0 : (lock_mask_q | lock_set);
  end

  always_ff @(posedge clk) begin
    if (rst) lock_mask_q <= '0;
    else     lock_mask_q <= lock_mask_d;
  end

  assign locked = !own_c_q && |(lock_mask_q & sel_onehot);
`else
  assign locked = 1'b0;
`endif

  assign reject  = !in_range || locked;
  assign b_rdata = b_rdata_q;
  assign c_rdata = c_rdata_q;

  always_comb begin
    state_d       = state_q;
    own_c_d       = own_c_q;
    last_c_d      = last_c_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    b_rdata_d     = b_rdata_q;
    c_rdata_d     = c_rdata_q;
    grant_c       = 1'b0;
    save_info_bus = '0;
    send_info_bus = '0;
    save_info_reg = '0;
    send_info_reg = '0;
    save_data_bus = '0;
    save_data_reg = '0;
    b_ack         = 1'b0;
    c_ack         = 1'b0;
    b_err         = 1'b0;
    c_err         = 1'b0;
    case (state_q)
      IDLE: begin
        if (b_req || c_req) begin
          // On a tie the side that did not win last time gets the grant.
          grant_c  = c_req && (!b_req || !last_c_q);
          own_c_d  = grant_c;
          last_c_d = grant_c;
          we_d     = grant_c ? c_we    : b_we;
          addr_d   = grant_c ? c_addr  : b_addr;
          wdata_d  = grant_c ? c_wdata : b_wdata;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        err_d = reject;
        if (reject) begin
          state_d = RESP;
        end else if (we_q) begin
          if (own_c_q) begin
            save_info_reg = sel_onehot;
            save_data_reg = wdata_q;
          end else begin
            save_info_bus = sel_onehot;
            save_data_bus = wdata_q;
          end
          state_d = RESP;
        end else begin
          if (own_c_q) send_info_reg = sel_onehot;
          else         send_info_bus = sel_onehot;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (own_c_q) c_rdata_d = rd_slice;
        else         b_rdata_d = rd_slice;
        state_d = RESP;
      end
      RESP: begin
        if (own_c_q) begin
          c_ack = 1'b1;
          c_err = err_q;
        end else begin
          b_ack = 1'b1;
          b_err = err_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      own_c_q   <= 1'b0;
      last_c_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      b_rdata_q <= '0;
      c_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      own_c_q   <= own_c_d;
      last_c_q  <= last_c_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      b_rdata_q <= b_rdata_d;
      c_rdata_q <= c_rdata_d;
    end
  end

endmodule
